// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Widths, PC step, FSM state encoding and the {instr, pc} payload struct.
package fetch_ctrl_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [WORD_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [WORD_W-1:0]  pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an {instr, pc} payload while decode stalls.
// Flush wins over fill; fill and drain are never requested together.
module fetch_skid
    import fetch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fill,
    input  logic       drain,
    input  logic       flush,
    input  fetch_pkt_t load_pkt,
    output logic       valid,
    output fetch_pkt_t held_pkt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            held_pkt <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid    <= 1'b1;
            held_pkt <= load_pkt;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instr_mem read per cycle, tracks the
// in-flight read and presents {instr, pc} to decode with a skid buffer and fault tracking.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 32'h0,
    parameter int unsigned       IMEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [WORD_W-1:0]  redirect_pc,
    output logic [WORD_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [WORD_W-1:0]  out_pc,
    output logic               fault,
    output logic [WORD_W-1:0]  fault_pc
);

    localparam logic [WORD_W:0] PC_LIMIT = (WORD_W+1)'(IMEM_WORDS) << 2;

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q;
    logic              infl_v;
    logic [WORD_W-1:0] infl_pc;
    logic              fault_q;
    logic [WORD_W-1:0] fault_pc_q;

    logic              bad_pc;
    logic              issue;
    logic              fault_set;
    logic              fault_clr;
    logic              skid_v;
    logic              skid_fill;
    logic              skid_drain;
    fetch_pkt_t        skid_pkt;
    fetch_pkt_t        infl_pkt;

    assign bad_pc = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= PC_LIMIT);

    // A new read may only start if its data will have somewhere to land next cycle.
    assign issue = (state_q == FETCH_RUN) && !redirect_valid && !bad_pc
                   && (out_ready || (!skid_v && !infl_v));

    assign fault_set = (state_q == FETCH_RUN) && !redirect_valid && fetch_en && bad_pc;
    assign fault_clr = (state_q == FETCH_FAULT) && redirect_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: begin
                if (!redirect_valid && fetch_en) state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (!redirect_valid) begin
                    if (!fetch_en)   state_d = FETCH_IDLE;
                    else if (bad_pc) state_d = FETCH_FAULT;
                end
            end
            FETCH_FAULT: begin
                if (redirect_valid) state_d = FETCH_RUN;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= FETCH_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            infl_v     <= 1'b0;
            infl_pc    <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            infl_v  <= issue;
            infl_pc <= pc_q;
            if (redirect_valid)  pc_q <= redirect_pc;
            else if (issue)      pc_q <= pc_q + PC_STEP;
            if (fault_set) begin
                fault_q    <= 1'b1;
                fault_pc_q <= pc_q;
            end else if (fault_clr) begin
                fault_q <= 1'b0;
            end
        end
    end

    assign infl_pkt   = '{instr: imem_instr, pc: infl_pc};
    assign skid_fill  = infl_v && !skid_v && !out_ready;
    assign skid_drain = skid_v && out_ready;

    fetch_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .fill     (skid_fill),
        .drain    (skid_drain),
        .flush    (redirect_valid),
        .load_pkt (infl_pkt),
        .valid    (skid_v),
        .held_pkt (skid_pkt)
    );

    always_comb begin
        out_instr = '0;
        out_pc    = '0;
        if (skid_v) begin
            out_instr = skid_pkt.instr;
            out_pc    = skid_pkt.pc;
        end else if (infl_v) begin
            out_instr = imem_instr;
            out_pc    = infl_pc;
        end
    end

    assign out_valid = !redirect_valid && (skid_v || infl_v);
    assign imem_addr = pc_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: streaming, stall/skid, redirect, fault, misalign, reset mid-stall.
// A behavioural instr_mem returns a PC-derived word one cycle after the address.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fault_pc;

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hB000_0000 | {22'h0, a[11:2]};
    endfunction

    always @(posedge clk) imem_instr <= instr_of(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
        check({tag, ".valid"}, {31'h0, out_valid}, {31'h0, v});
        if (v) begin
            check({tag, ".pc"}, out_pc, pc);
            check({tag, ".instr"}, out_instr, instr_of(pc));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        step();
        step();
        #1;
        expect_out("reset", 1'b0, 32'h0);
        check("reset.out_pc", out_pc, 32'h0);
        check("reset.out_instr", out_instr, 32'h0);
        check("reset.fault", {31'h0, fault}, 32'h0);
        check("reset.fault_pc", fault_pc, 32'h0);
        check("reset.addr", imem_addr, 32'h0);

        // Streaming: first instruction two edges after fetch_en
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        step(); expect_out("stream0", 1'b0, 32'h0);
        step(); expect_out("stream1", 1'b1, 32'h0);
        step(); expect_out("stream2", 1'b1, 32'h4);
        step();
        out_ready = 1'b0;
        #1;
        expect_out("stall0", 1'b1, 32'h8);
        check("stall0.addr", imem_addr, 32'hC);
        step(); expect_out("stall1", 1'b1, 32'h8);
        step(); expect_out("stall2", 1'b1, 32'h8);
        check("stall2.addr", imem_addr, 32'hC);
        step();
        out_ready = 1'b1;
        #1;
        expect_out("stall_rel", 1'b1, 32'h8);
        step(); expect_out("after_stall0", 1'b1, 32'hC);
        step(); expect_out("after_stall1", 1'b1, 32'h10);

        // Redirect while skid holds 0x10
        out_ready = 1'b0;
        #1;
        expect_out("fill0", 1'b1, 32'h10);
        step(); expect_out("fill1", 1'b1, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        expect_out("redir0", 1'b0, 32'h0);
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        #1;
        expect_out("redir1", 1'b0, 32'h0);
        check("redir1.addr", imem_addr, 32'h40);
        step(); expect_out("redir2", 1'b1, 32'h40);
        step(); expect_out("redir3", 1'b1, 32'h44);

        // Fault at end of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0FFC;
        #1;
        expect_out("endmem0", 1'b0, 32'h0);
        step();
        redirect_valid = 1'b0;
        #1;
        expect_out("endmem1", 1'b0, 32'h0);
        check("endmem1.fault", {31'h0, fault}, 32'h0);
        step(); expect_out("endmem2", 1'b1, 32'hFFC);
        check("endmem2.fault", {31'h0, fault}, 32'h0);
        step(); expect_out("endmem3", 1'b0, 32'h0);
        check("endmem3.fault", {31'h0, fault}, 32'h1);
        check("endmem3.fault_pc", fault_pc, 32'h1000);
        step(); expect_out("endmem4", 1'b0, 32'h0);
        check("endmem4.fault", {31'h0, fault}, 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        #1;
        check("clear.fault", {31'h0, fault}, 32'h0);
        expect_out("clear0", 1'b0, 32'h0);
        step(); expect_out("clear1", 1'b1, 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        step();
        redirect_valid = 1'b0;
        #1;
        check("mis0.fault", {31'h0, fault}, 32'h0);
        check("mis0.addr", imem_addr, 32'h6);
        expect_out("mis0", 1'b0, 32'h0);
        step();
        check("mis1.fault", {31'h0, fault}, 32'h1);
        check("mis1.fault_pc", fault_pc, 32'h6);
        expect_out("mis1", 1'b0, 32'h0);
        step(); expect_out("mis2", 1'b0, 32'h0);

        // Reset while the skid is full
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        expect_out("rst_stall0", 1'b0, 32'h0);
        step(); expect_out("rst_stall1", 1'b1, 32'h100);
        step(); expect_out("rst_stall2", 1'b1, 32'h100);
        check("rst_stall2.addr", imem_addr, 32'h104);
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        expect_out("rst_mid0", 1'b0, 32'h0);
        check("rst_mid0.addr", imem_addr, 32'h0);
        check("rst_mid0.fault", {31'h0, fault}, 32'h0);
        step(); expect_out("idle0", 1'b0, 32'h0);
        check("idle0.addr", imem_addr, 32'h0);
        step(); expect_out("idle1", 1'b0, 32'h0);
        fetch_en = 1'b1;
        step(); expect_out("restart0", 1'b0, 32'h0);
        step(); expect_out("restart1", 1'b1, 32'h0);
        step(); expect_out("restart2", 1'b1, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
